// File: rtl/debug_dump_unit.sv
// debug_dump_unit: serialises PC, register file and data memory
// into a little-endian byte stream for the UART transmitter.
module debug_dump_unit #(
  parameter int NB_DATA     = 32,
  parameter int N_BITS      = 8,
  parameter int NB_REG      = 5,
  parameter int N_REGISTER  = 32,
  parameter int NB_ADDR     = 7,
  parameter int N_MEM_WORDS = 128,
  parameter int NB_PC       = 7
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [2:0]         mask_i,
  input  logic               abort_i,
  input  logic [NB_PC-1:0]   pc_i,
  input  logic [NB_DATA-1:0] reg_data_i,
  input  logic [NB_DATA-1:0] mem_data_i,
  input  logic               tx_done_i,
  output logic               reg_sel_o,
  output logic [NB_REG-1:0]  reg_addr_o,
  output logic               mem_sel_o,
  output logic [NB_ADDR-1:0] mem_addr_o,
  output logic               tx_start_o,
  output logic [N_BITS-1:0]  tx_data_o,
  output logic               hold_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int N_BYTES = NB_DATA / N_BITS;
  localparam int NB_BCNT = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  localparam logic [NB_BCNT-1:0] BYTE_LAST =
    NB_BCNT'(N_BYTES - 1);
  localparam logic [NB_REG-1:0]  REG_LAST  =
    NB_REG'(N_REGISTER - 1);
  localparam logic [NB_ADDR-1:0] MEM_LAST  =
    NB_ADDR'(N_MEM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_ADDR,
    S_MEM_WAIT,
    S_LOAD,
    S_SEND,
    S_WAIT_TX,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SEC_HDR,
    SEC_PC,
    SEC_REG,
    SEC_MEM
  } sect_t;

  state_t               state;
  state_t               state_n;
  sect_t                sect;
  sect_t                nx_sect;
  logic                 nx_valid;
  logic [2:0]           mask_q;
  logic [NB_REG-1:0]    reg_idx;
  logic [NB_ADDR-1:0]   mem_idx;
  logic [NB_BCNT-1:0]   bcnt;
  logic [NB_DATA-1:0]   word_q;
  logic [NB_DATA-1:0]   shreg;
  logic                 word_last;
  logic                 idx_more;
  logic                 leave;

  // first enabled section after the current one
  always_comb begin
    nx_valid = 1'b0;
    nx_sect  = SEC_PC;
    unique case (sect)
      SEC_HDR: begin
        if (mask_q[0]) begin
          nx_valid = 1'b1;
          nx_sect  = SEC_PC;
        end else if (mask_q[1]) begin
          nx_valid = 1'b1;
          nx_sect  = SEC_REG;
        end else if (mask_q[2]) begin
          nx_valid = 1'b1;
          nx_sect  = SEC_MEM;
        end
      end
      SEC_PC: begin
        if (mask_q[1]) begin
          nx_valid = 1'b1;
          nx_sect  = SEC_REG;
        end else if (mask_q[2]) begin
          nx_valid = 1'b1;
          nx_sect  = SEC_MEM;
        end
      end
      SEC_REG: begin
        if (mask_q[2]) begin
          nx_valid = 1'b1;
          nx_sect  = SEC_MEM;
        end
      end
      default: begin
        nx_valid = 1'b0;
      end
    endcase
  end

  assign word_last = (sect == SEC_HDR) || (bcnt == BYTE_LAST);

  assign idx_more =
    ((sect == SEC_REG) && (reg_idx != REG_LAST)) ||
    ((sect == SEC_MEM) && (mem_idx != MEM_LAST));

  // abort cancels any active dump, beating tx_done in the same cycle
  assign leave = abort_i && (state != S_IDLE);

  // state register
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next-state decode
  always_comb begin
    state_n = state;
    if (leave) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_i && !abort_i) state_n = S_HEADER;
        end
        S_HEADER: begin
          state_n = S_SEND;
        end
        S_ADDR: begin
          if (sect == SEC_MEM) state_n = S_MEM_WAIT;
          else                 state_n = S_LOAD;
        end
        S_MEM_WAIT: begin
          state_n = S_LOAD;
        end
        S_LOAD: begin
          state_n = S_SEND;
        end
        S_SEND: begin
          state_n = S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (tx_done_i) begin
            if (!word_last)
              state_n = S_SEND;
            else if (idx_more || nx_valid)
              state_n = S_ADDR;
            else
              state_n = S_DONE;
          end
        end
        S_DONE: begin
          state_n = S_IDLE;
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // section/index/byte bookkeeping and word shift register
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      mask_q  <= '0;
      sect    <= SEC_HDR;
      reg_idx <= '0;
      mem_idx <= '0;
      bcnt    <= '0;
      word_q  <= '0;
      shreg   <= '0;
    end else if (leave || (state == S_DONE)) begin
      mask_q  <= '0;
      sect    <= SEC_HDR;
      reg_idx <= '0;
      mem_idx <= '0;
      bcnt    <= '0;
      word_q  <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            mask_q  <= mask_i;
            sect    <= SEC_HDR;
            reg_idx <= '0;
            mem_idx <= '0;
            bcnt    <= '0;
          end
        end
        S_HEADER: begin
          shreg <= NB_DATA'(mask_q);
        end
        S_ADDR: begin
          if (sect == SEC_PC)
            word_q <= NB_DATA'(pc_i);
          else if (sect == SEC_REG)
            word_q <= reg_data_i;
        end
        S_MEM_WAIT: begin
          word_q <= mem_data_i;
        end
        S_LOAD: begin
          shreg <= word_q;
          bcnt  <= '0;
        end
        S_WAIT_TX: begin
          if (tx_done_i) begin
            shreg <= shreg >> N_BITS;
            bcnt  <= bcnt + NB_BCNT'(1);
            if (word_last) begin
              if ((sect == SEC_REG) && (reg_idx != REG_LAST))
                reg_idx <= reg_idx + NB_REG'(1);
              else if ((sect == SEC_MEM) && (mem_idx != MEM_LAST))
                mem_idx <= mem_idx + NB_ADDR'(1);
              else if (nx_valid)
                sect <= nx_sect;
            end
          end
        end
        default: begin
          bcnt <= bcnt;
        end
      endcase
    end
  end

  assign busy_o = (state != S_IDLE) && (state != S_DONE);
  assign hold_o = busy_o;
  assign done_o = (state == S_DONE);

  assign tx_start_o = (state == S_SEND);
  assign tx_data_o  =
    ((state == S_SEND) || (state == S_WAIT_TX)) ?
    shreg[N_BITS-1:0] : '0;

  assign reg_sel_o  = busy_o && (sect == SEC_REG);
  assign mem_sel_o  = busy_o && (sect == SEC_MEM);
  assign reg_addr_o = reg_sel_o ? reg_idx : '0;
  assign mem_addr_o = mem_sel_o ? mem_idx : '0;

endmodule

// File: doc/debug_dump_unit.md
Name: debug_dump_unit

Overview:
- Parametrised successor to the processor's debug-dump path. On command it serialises the PC, the register file and data memory into a byte stream for the UART transmitter.
- Each source (PC, registers, memory) is selected independently by a mask.
- Read-port steering and pipeline hold are under its own control.
- Sits between the pipeline's debug read ports (decode register file, mem stage data memory, fetch/decode PC) and the tx_uart byte interface.

Parameters:
- NB_DATA, 32, width of one dumped word; must be a multiple of N_BITS.
- N_BITS, 8, UART byte width.
- NB_REG, 5, register address width.
- N_REGISTER, 32, number of registers dumped (≤ 2^NB_REG).
- NB_ADDR, 7, data memory word-address width.
- N_MEM_WORDS, 128, number of memory words dumped (≤ 2^NB_ADDR).
- NB_PC, 7, PC width; zero-extended to NB_DATA when sent.

Ports:
- clock_i, in, 1, system clock.
- reset_i, in, 1, asynchronous active-low reset.
- start_i, in, 1, single-cycle dump request.
- mask_i, in, 3, source select: bit0 PC, bit1 registers, bit2 memory. Sampled with start_i.
- abort_i, in, 1, cancel the dump in progress.
- pc_i, in, NB_PC, current PC.
- reg_data_i, in, NB_DATA, register read data (combinational read of reg_addr_o).
- mem_data_i, in, NB_DATA, memory read data (valid one cycle after mem_addr_o).
- tx_done_i, in, 1, transmitter finished the current byte.
- reg_sel_o, out, 1, steers the register read port to reg_addr_o.
- reg_addr_o, out, NB_REG, register being read.
- mem_sel_o, out, 1, steers the memory address mux to mem_addr_o.
- mem_addr_o, out, NB_ADDR, memory word being read.
- tx_start_o, out, 1, byte-valid pulse to the transmitter.
- tx_data_o, out, N_BITS, byte to send.
- hold_o, out, 1, freezes the pipeline (en_pipeline low) while high.
- busy_o, out, 1, dump in progress.
- done_o, out, 1, one-cycle pulse when a dump completes.

Behaviour:
- Reset (asynchronous, reset_i=0): state IDLE. All outputs 0; all counters and shift registers 0.
- IDLE:
  - start_i=1 latches mask_i into mask_q and asserts busy_o and hold_o from the next cycle. Next state HEADER.
  - start_i while busy is ignored.
- HEADER: loads the header byte {(N_BITS-3) zeros, mask_q} into tx_data_o, then goes to SEND. The header is sent even when mask_q=0; in that case the next stop is DONE.
- Section order: PC, then registers 0..N_REGISTER-1, then memory 0..N_MEM_WORDS-1. Sections with a clear mask bit are skipped with zero-cycle cost.
- ADDR:
  - Drives the index onto the selected source: reg_sel_o=1 during the register section, mem_sel_o=1 during the memory section.
  - Register and PC sections: word captured in the same cycle, next state LOAD.
  - Memory section: one wait cycle, then capture.
- LOAD: captures the NB_DATA word into a shift register and clears the byte counter.
- SEND:
  - Puts the low N_BITS of the shift register on tx_data_o.
  - Pulses tx_start_o for exactly 1 cycle, then goes to WAIT_TX.
  - tx_data_o stays stable until tx_done_i.
- WAIT_TX:
  - Waits for tx_done_i; tx_done_i is ignored in every other state.
  - On tx_done_i the shift register shifts right by N_BITS and the byte counter increments.
  - If NB_DATA/N_BITS bytes are not yet sent, return to SEND.
  - Otherwise the word index increments and the next state is ADDR, the next section, or DONE.
- Byte order: little-endian (LSB first). Word count per dump = mask0 + N_REGISTER·mask1 + N_MEM_WORDS·mask2. Total bytes = 1 + (NB_DATA/N_BITS)·word count.
- DONE: done_o=1 for one cycle; busy_o, hold_o and both sel outputs drop to 0 in that same cycle. Next state IDLE.
- Index counters stop at N_REGISTER-1 and N_MEM_WORDS-1; there is no wrap into a second pass.
- abort_i, any non-IDLE state: next state IDLE. All outputs 0 next cycle, no done_o pulse, any byte in flight is abandoned. abort_i wins over tx_done_i in the same cycle.
- start_i and abort_i together in IDLE: the start is ignored.
- Asynchronous reset mid-dump: immediate return to IDLE values.

Test Plan:
- Reset with start_i=1 held: all outputs 0, stays IDLE until reset_i=1; then start_i is accepted on the next cycle.
- mask=3'b001, pc_i=7'h15, tx_done_i 3 cycles after each tx_start_o:
  - Required bytes: 8'h01, 8'h15, 8'h00, 8'h00, 8'h00.
  - done_o pulses once; tx_start_o pulses exactly 5 times.
- mask=3'b010, reg_data_i = 32'hA0000000+addr:
  - Required: 129 bytes; register 31 sends 8'h1F, 00, 00, A0.
  - reg_sel_o high from the first ADDR to DONE; hold_o high throughout.
- mask=3'b100, mem word i = i·4, one-cycle read:
  - Required: 513 bytes; word 127 sends FC, 01, 00, 00.
  - mem_addr_o never exceeds 7'h7F.
- mask=3'b000: only header byte 8'h00 is sent, then done_o.
- abort_i during register 10, byte 2: outputs return to 0 next cycle, no done_o; a new start_i afterwards produces a full fresh dump beginning with the header.
